// File: rtl/arm32_pkg.sv
// Shared ARM32 decode types and constants for the operand-fetch stage.
package arm32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_class_t;

  localparam logic [3:0]      REG_PC         = 4'd15;
  localparam logic [XLEN-1:0] PC_READ_OFFSET = 32'd8;

  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam logic [3:0] OPC_MVN = 4'b1111;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of fetch, register-file, writeback, load-tracking and ID/EX signals.
interface operand_fetch_stage_if;
  import arm32_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [3:0]      rf_a1;
  logic [3:0]      rf_a2;
  logic [XLEN-1:0] rf_r15;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic            wb_we;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ld_busy;
  logic [3:0]      ld_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_rd;

  // The stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, rf_rd1, rf_rd2, wb_we, wb_addr, wb_data,
           ld_busy, ld_rd, flush, out_ready,
    output in_ready, rf_a1, rf_a2, rf_r15, out_valid, out_instr, out_pc,
           out_op1, out_op2, out_imm, out_rd
  );

  // Fetch, register file, writeback and execute side.
  modport master (
    output in_valid, in_instr, in_pc, rf_rd1, rf_rd2, wb_we, wb_addr, wb_data,
           ld_busy, ld_rd, flush, out_ready,
    input  in_ready, rf_a1, rf_a2, rf_r15, out_valid, out_instr, out_pc,
           out_op1, out_op2, out_imm, out_rd
  );

endinterface

// File: rtl/operand_fetch_stage_imm_extend.sv
// Combinational immediate extraction per instruction class.
// DP rotates imm8, MEM zero-extends imm12, BR sign-extends imm24 as a word offset.
module imm_extend
  import arm32_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  input  op_class_t       i_class,
  output logic [XLEN-1:0] o_imm
);

  logic [2*XLEN-1:0] w_rot;
  logic [4:0]        w_amt;

  assign w_amt = {i_instr[11:8], 1'b0};
  // Rotate by shifting a doubled copy; avoids a shift-by-32 corner at zero rotation.
  assign w_rot = {24'd0, i_instr[7:0], 24'd0, i_instr[7:0]} >> w_amt;

  always_comb begin
    o_imm = w_rot[XLEN-1:0];
    case (i_class)
      OP_MEM:  o_imm = {20'd0, i_instr[11:0]};
      OP_BR:   o_imm = {{6{i_instr[23]}}, i_instr[23:0], 2'b00};
      default: o_imm = w_rot[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: register reads with same-cycle forwarding into a
// one-entry ID/EX register, stalling on load-use hazards and honouring flush.
module operand_fetch_stage
  import arm32_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  operand_fetch_stage_if.slave  bus
);

  op_class_t       w_class;
  logic [3:0]      w_opc;
  logic [3:0]      w_a1;
  logic [3:0]      w_a2;
  logic            w_reads_a1;
  logic            w_reads_a2;
  logic            w_hazard;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_imm;

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_rd;

  assign w_class = op_class_t'(bus.in_instr[27:26]);
  assign w_opc   = bus.in_instr[24:21];
  assign w_a1    = bus.in_instr[19:16];
  assign w_a2    = (w_class == OP_MEM && !bus.in_instr[20]) ? bus.in_instr[15:12]
                                                             : bus.in_instr[3:0];

  always_comb begin
    w_reads_a1 = 1'b0;
    w_reads_a2 = 1'b0;
    case (w_class)
      OP_MEM: begin
        w_reads_a1 = 1'b1;
        w_reads_a2 = 1'b1;
      end
      OP_BR: ;
      default: begin
        w_reads_a1 = (w_opc != OPC_MOV) && (w_opc != OPC_MVN);
        w_reads_a2 = !bus.in_instr[25];
      end
    endcase
  end

  // R15 is never a load-use hazard: it is served from the PC, not the file.
  assign w_hazard = bus.ld_busy &&
                    ((w_reads_a1 && w_a1 != REG_PC && bus.ld_rd == w_a1) ||
                     (w_reads_a2 && w_a2 != REG_PC && bus.ld_rd == w_a2));

  assign w_op1 = (w_a1 != REG_PC && bus.wb_we && bus.wb_addr == w_a1) ? bus.wb_data : bus.rf_rd1;
  assign w_op2 = (w_a2 != REG_PC && bus.wb_we && bus.wb_addr == w_a2) ? bus.wb_data : bus.rf_rd2;

  imm_extend u_imm_extend (
    .i_instr (bus.in_instr),
    .i_class (w_class),
    .o_imm   (w_imm)
  );

  assign bus.in_ready = (!r_valid || bus.out_ready) && !w_hazard;
  assign w_in_xfer    = bus.in_valid && bus.in_ready;
  assign w_out_xfer   = r_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_instr <= bus.in_instr;
      r_pc    <= bus.in_pc;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_imm   <= w_imm;
      r_rd    <= bus.in_instr[15:12];
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.rf_a1     = w_a1;
  assign bus.rf_a2     = w_a2;
  assign bus.rf_r15    = bus.in_pc + PC_READ_OFFSET;
  assign bus.out_valid = r_valid;
  assign bus.out_instr = r_instr;
  assign bus.out_pc    = r_pc;
  assign bus.out_op1   = r_op1;
  assign bus.out_op2   = r_op2;
  assign bus.out_imm   = r_imm;
  assign bus.out_rd    = r_rd;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; a small register-file model answers reads.
module tb_operand_fetch_stage;
  import arm32_pkg::*;

  localparam logic [31:0] I_ADD  = 32'hE0821003; // ADD R1,R2,R3
  localparam logic [31:0] I_ADDP = 32'hE08F1003; // ADD R1,PC,R3
  localparam logic [31:0] I_MOV  = 32'hE3A004FF; // MOV R0,#0xFF000000
  localparam logic [31:0] I_B    = 32'hEAFFFFFE; // B .
  localparam logic [31:0] I_STR  = 32'hE5865004; // STR R5,[R6,#4]

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  operand_fetch_stage_if bus();

  operand_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: Rn holds 0x1000_0000 + n; R15 returns the stage's PC view.
  always_comb begin
    bus.rf_rd1 = (bus.rf_a1 == 4'd15) ? bus.rf_r15 : (32'h1000_0000 + {28'd0, bus.rf_a1});
    bus.rf_rd2 = (bus.rf_a2 == 4'd15) ? bus.rf_r15 : (32'h1000_0000 + {28'd0, bus.rf_a2});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.wb_we     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.ld_busy   = 1'b0;
    bus.ld_rd     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_op1", bus.out_op1, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Basic transfer
    present(I_ADD, 32'h40);
    #1;
    chk("add_rf_a1", {28'd0, bus.rf_a1}, 32'd2);
    chk("add_rf_a2", {28'd0, bus.rf_a2}, 32'd3);
    chk("add_rf_r15", bus.rf_r15, 32'h48);
    tick();
    bus.in_valid = 1'b0;
    chk("add_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add_out_instr", bus.out_instr, I_ADD);
    chk("add_out_pc", bus.out_pc, 32'h40);
    chk("add_op1", bus.out_op1, 32'h1000_0002);
    chk("add_op2", bus.out_op2, 32'h1000_0003);
    chk("add_rd", {28'd0, bus.out_rd}, 32'd1);
    tick();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Same-cycle writeback forwarding
    present(I_ADD, 32'h44);
    bus.wb_we   = 1'b1;
    bus.wb_addr = 4'd2;
    bus.wb_data = 32'hDEAD_BEEF;
    tick();
    chk("fwd_op1", bus.out_op1, 32'hDEAD_BEEF);
    chk("fwd_op2", bus.out_op2, 32'h1000_0003);

    // PC read ignores a writeback to R15
    present(I_ADDP, 32'h100);
    bus.wb_addr = 4'd15;
    bus.wb_data = 32'h1234_5678;
    #1;
    chk("pc_rf_r15", bus.rf_r15, 32'h108);
    tick();
    chk("pc_op1", bus.out_op1, 32'h108);
    bus.wb_we = 1'b0;

    // Immediates, back-to-back
    present(I_MOV, 32'h200);
    tick();
    chk("mov_imm", bus.out_imm, 32'hFF00_0000);
    present(I_B, 32'h204);
    tick();
    chk("br_imm", bus.out_imm, 32'hFFFF_FFF8);
    chk("br_b2b_pc", bus.out_pc, 32'h204);
    present(I_STR, 32'h208);
    #1;
    chk("str_rf_a1", {28'd0, bus.rf_a1}, 32'd6);
    chk("str_rf_a2", {28'd0, bus.rf_a2}, 32'd5);
    tick();
    chk("str_imm", bus.out_imm, 32'd4);
    chk("str_op2", bus.out_op2, 32'h1000_0005);

    // MOV immediate reads nothing, so ld_rd matching Rn is not a hazard
    present(I_MOV, 32'h20C);
    bus.ld_busy = 1'b1;
    bus.ld_rd   = 4'd0;
    #1;
    chk("mov_no_hazard", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    tick();

    // Load-use stall on R2
    present(I_ADD, 32'h300);
    bus.ld_rd = 4'd2;
    #1;
    chk("lu_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("lu_drained", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("lu_still_stalled", {31'd0, bus.in_ready}, 32'd0);
    bus.ld_busy = 1'b0;
    #1;
    chk("lu_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("lu_accept_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lu_accept_pc", bus.out_pc, 32'h300);

    // Backpressure holds the ADD while a MOV waits
    bus.out_ready = 1'b0;
    present(I_MOV, 32'h304);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_instr", bus.out_instr, I_ADD);
      chk("bp_op1", bus.out_op1, 32'h1000_0002);
      chk("bp_pc", bus.out_pc, 32'h300);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_b2b_instr", bus.out_instr, I_MOV);
    present(I_B, 32'h308);
    tick();
    chk("bp_b2b_br", bus.out_instr, I_B);

    // Flush drops both held and incoming
    present(I_STR, 32'h30C);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset during a held stall
    present(I_ADD, 32'h400);
    tick();
    bus.out_ready = 1'b0;
    bus.ld_busy   = 1'b1;
    bus.ld_rd     = 4'd2;
    tick();
    chk("stall_held", {31'd0, bus.out_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst2_instr", bus.out_instr, 32'd0);
    chk("rst2_pc", bus.out_pc, 32'd0);
    chk("rst2_op1", bus.out_op1, 32'd0);
    chk("rst2_imm", bus.out_imm, 32'd0);
    chk("rst2_rd", {28'd0, bus.out_rd}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode/operand-fetch pipeline stage of the ARM32 core, between instruction fetch and execute. Accepts a fetched instruction and its PC over a valid/ready handshake, and drives the register-file read addresses and the R15 value. It takes the two combinational read values, forwards same-cycle writeback data, extends the immediate, and registers everything into a one-entry ID/EX pipeline register. It also stalls on load-use hazards and supports flush from branch resolution.

## Interface
- XLEN, 32, datapath width
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  XLEN  instruction word
- in_pc  in  XLEN  address of in_instr
- rf_a1  out  4  register-file read address 1 (Rn)
- rf_a2  out  4  register-file read address 2 (Rm, or Rd for stores)
- rf_r15  out  XLEN  value the register file returns for address 15
- rf_rd1, rf_rd2  in  XLEN  register-file read data
- wb_we  in  1  writeback writing this cycle
- wb_addr  in  4  writeback register
- wb_data  in  XLEN  writeback data
- ld_busy  in  1  load in execute will write ld_rd
- ld_rd  in  4  destination of that load
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute accepts
- out_instr, out_pc  out  XLEN  registered instruction and PC
- out_op1, out_op2  out  XLEN  registered operands
- out_imm  out  XLEN  registered extended immediate
- out_rd  out  4  registered instr[15:12]

## Operation
- Class op = instr[27:26]: 00 data-processing (DP), 01 memory (MEM), 10 branch (BR), 11 undefined; treat 11 as DP.
- rf_a1 = instr[19:16].
- rf_a2 = instr[15:12] for MEM with L = instr[20] = 0 (store). Otherwise rf_a2 = instr[3:0].
- rf_r15 = in_pc + 8, modulo 2^32.
- Operand selection per port: address 15 uses rf_rdN unchanged, because the register file already supplies rf_r15. Otherwise, if wb_we and wb_addr == address, use wb_data. Otherwise use rf_rdN.
- Immediate:
  - DP: imm8 = instr[7:0] rotated right by 2*instr[11:8].
  - MEM: instr[11:0] zero-extended.
  - BR: instr[23:0] sign-extended, then shifted left by 2.
- Reads per class: DP reads A1 if opcode instr[24:21] is not MOV/MVN, and reads A2 if I = instr[25] = 0. MEM reads A1 and A2. BR reads none.
- Hazard: hazard = ld_busy and ld_rd equals a read address (≠15).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - A transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Register update priority: reset, then flush (out_valid ← 0), then transfer in (load all out_* and out_valid ← 1), then output transfer without input (out_valid ← 0), then hold.
- A held output is stable (all out_* unchanged) while out_valid && !out_ready.

## Timing
- Reset values: out_valid = 0 and all out_* = 0. in_ready = 1 when no hazard is present.
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* in cycle N+1.
- Throughput is 1 per cycle when out_ready = 1.
- Forwarding applies only to a write in the same cycle. Older writes are already in the register file.
- A flush in the same cycle as in_valid drops that instruction.
- Reset asserted mid-stall clears out_valid. Fetch must re-present the instruction afterwards.
- hazard deasserts combinationally once ld_busy falls. The instruction is accepted that cycle.
- in_ready, rf_a1, rf_a2 and rf_r15 are combinational from the inputs. out_* are registered only.

## Structure
- arm32_pkg holds:
  - op_class_t enum (OP_DP, OP_MEM, OP_BR, OP_UND).
  - REG_PC = 4'd15 and PC_READ_OFFSET = 32'd8.
  - MOV/MVN opcode constants.
- One sub-module, imm_extend: combinational, with inputs instr and class and output imm.

## Test plan
- Transfer after reset: in_instr 0xE0821003 (ADD R1,R2,R3), pc 0x40 → rf_a1 = 2, rf_a2 = 3, rf_r15 = 0x48. Next cycle: out_valid = 1, out_op1/out_op2 = R2/R3, out_rd = 1.
- Writeback forwarding: wb_we = 1, wb_addr = 2, wb_data = 0xDEADBEEF while accepting the ADD above → out_op1 = 0xDEADBEEF. A PC read (Rn = 15, pc 0x100) yields 0x108 even with wb_addr = 15.
- Immediates:
  - 0xE3A004FF → out_imm = 0xFF000000.
  - 0xEAFFFFFE → out_imm = 0xFFFFFFF8.
  - STR R5,[R6,#4] (0xE5865004) → rf_a1 = 6, rf_a2 = 5, out_imm = 4.
- Load-use stall: ld_busy = 1 with ld_rd = 2 while presenting the ADD → in_ready = 0 and out_valid falls after the drain. Dropping ld_busy → accepted next edge.
- Backpressure: out_ready = 0 for 3 cycles with a held instruction → out_* constant and in_ready = 0. Raising out_ready with a new in_valid → back-to-back transfer.
- Flush/reset: flush with out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle. Reset during a held stall → all outputs zero next cycle.
